// File: rtl/ov5640_frame_wr_ctrl.sv
// Write-side scheduler: buffers OV5640 RGB565 pixels in a FIFO, issues burst
// write requests to the frame-buffer writer and ping-pongs between two banks.
module ov5640_frame_wr_ctrl #(
  parameter int                BURST_LEN    = 64,
  parameter int                FIFO_DEPTH   = 256,
  parameter int                ADDR_W       = 24,
  parameter int                FRAME_PIXELS = 307200,
  parameter logic [ADDR_W-1:0] BANK0_BASE   = 24'h000000,
  parameter logic [ADDR_W-1:0] BANK1_BASE   = 24'h080000
) (
  input  logic              cam_pclk,
  input  logic              rst,
  input  logic              enable,
  input  logic              cmos_frame_vsync,
  input  logic              cmos_frame_valid,
  input  logic [15:0]       cmos_frame_data,
  output logic              wr_req,
  input  logic              wr_ack,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_len,
  output logic [15:0]       wr_data,
  input  logic              wr_data_rd,
  input  logic              wr_done,
  output logic              disp_bank,
  output logic              disp_valid,
  output logic              frame_done,
  output logic              ovf,
  output logic              busy
);

  localparam int CNT_W  = $clog2(FRAME_PIXELS + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  FRAME_CNT  = CNT_W'(FRAME_PIXELS);
  localparam logic [FCNT_W-1:0] BURST_CNT  = FCNT_W'(BURST_LEN);
  localparam logic [FCNT_W-1:0] FULL_CNT   = FCNT_W'(FIFO_DEPTH);
  localparam logic [7:0]        BURST_LEN8 = 8'(BURST_LEN);

  typedef enum logic [2:0] {IDLE, CAPT, REQ, BURST, DONE, ABORT} state_t;

  state_t state_reg, state_next;

  logic [15:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [FCNT_W-1:0] fifo_cnt_reg;

  logic [CNT_W-1:0]  in_cnt_reg, out_cnt_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [7:0]        wr_len_reg, len_next;
  logic              vsync_q_reg, frame_bad_reg, abort_pend_reg, wr_bank_reg;
  logic              disp_bank_reg, disp_valid_reg, frame_done_reg, ovf_reg;

  logic vs_rise, capturing, in_xfer;
  logic push_req, push_ok, push_drop, pop_ok, fifo_full;
  logic start_frame, load_burst, burst_fin, publish, flush;

  assign vs_rise   = cmos_frame_vsync && !vsync_q_reg;
  assign in_xfer   = (state_reg == REQ) || (state_reg == BURST);
  assign capturing = (state_reg == CAPT) || in_xfer;
  assign fifo_full = (fifo_cnt_reg == FULL_CNT);
  // Pixels past the frame length are ignored; pushes into a full FIFO are counted but lost.
  assign push_req  = capturing && cmos_frame_valid && (in_cnt_reg < FRAME_CNT);
  assign push_ok   = push_req && !fifo_full;
  assign push_drop = push_req && fifo_full;
  assign pop_ok    = wr_data_rd && (fifo_cnt_reg != '0);

  always_comb begin
    state_next  = state_reg;
    start_frame = 1'b0;
    load_burst  = 1'b0;
    len_next    = wr_len_reg;
    burst_fin   = 1'b0;
    publish     = 1'b0;
    flush       = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (vs_rise && enable) begin
          state_next  = CAPT;
          start_frame = 1'b1;
        end
      end
      CAPT: begin
        if (vs_rise) begin
          state_next = ABORT;
        end else if (fifo_cnt_reg >= BURST_CNT) begin
          state_next = REQ;
          load_burst = 1'b1;
          len_next   = BURST_LEN8;
        end else if (in_cnt_reg == FRAME_CNT && fifo_cnt_reg != '0) begin
          state_next = REQ;
          load_burst = 1'b1;
          len_next   = 8'(fifo_cnt_reg);
        end else if (out_cnt_reg == FRAME_CNT) begin
          state_next = DONE;
        end
      end
      REQ: begin
        if (wr_ack) state_next = BURST;
      end
      BURST: begin
        if (wr_done) begin
          burst_fin  = 1'b1;
          state_next = (abort_pend_reg || vs_rise) ? ABORT : CAPT;
        end
      end
      DONE: begin
        state_next = IDLE;
        publish    = !frame_bad_reg;
      end
      ABORT: begin
        flush = 1'b1;
        if (enable) begin
          state_next  = CAPT;
          start_frame = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge cam_pclk) begin
    if (rst) begin
      state_reg      <= IDLE;
      vsync_q_reg    <= 1'b1;
      in_cnt_reg     <= '0;
      out_cnt_reg    <= '0;
      wr_addr_reg    <= BANK0_BASE;
      wr_len_reg     <= '0;
      frame_bad_reg  <= 1'b0;
      abort_pend_reg <= 1'b0;
      wr_bank_reg    <= 1'b0;
      disp_bank_reg  <= 1'b0;
      disp_valid_reg <= 1'b0;
      frame_done_reg <= 1'b0;
      ovf_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      vsync_q_reg    <= cmos_frame_vsync;
      frame_done_reg <= publish;
      if (load_burst) wr_len_reg <= len_next;
      if (push_drop || (vs_rise && capturing)) ovf_reg <= 1'b1;
      if (flush) begin
        abort_pend_reg <= 1'b0;
      end else if (vs_rise && in_xfer) begin
        abort_pend_reg <= 1'b1;
      end
      if (start_frame) begin
        in_cnt_reg    <= '0;
        out_cnt_reg   <= '0;
        frame_bad_reg <= 1'b0;
        wr_addr_reg   <= wr_bank_reg ? BANK1_BASE : BANK0_BASE;
      end else begin
        if (push_req) in_cnt_reg <= in_cnt_reg + 1'b1;
        if (push_drop) frame_bad_reg <= 1'b1;
        if (burst_fin) begin
          wr_addr_reg <= wr_addr_reg + ADDR_W'(wr_len_reg);
          out_cnt_reg <= out_cnt_reg + CNT_W'(wr_len_reg);
        end
      end
      if (publish) begin
        disp_bank_reg  <= wr_bank_reg;
        disp_valid_reg <= 1'b1;
        wr_bank_reg    <= ~wr_bank_reg;
      end
    end
  end

  // Pixel FIFO: storage has no reset, only the pointers and count do.
  always_ff @(posedge cam_pclk) begin
    if (push_ok) mem[wr_ptr_reg] <= cmos_frame_data;
  end

  always_ff @(posedge cam_pclk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
    end else if (flush) begin
      rd_ptr_reg   <= wr_ptr_reg;
      fifo_cnt_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push_ok && !pop_ok) fifo_cnt_reg <= fifo_cnt_reg + 1'b1;
      else if (pop_ok && !push_ok) fifo_cnt_reg <= fifo_cnt_reg - 1'b1;
    end
  end

  assign wr_data    = mem[rd_ptr_reg];
  assign wr_req     = (state_reg == REQ);
  assign busy       = (state_reg != IDLE);
  assign wr_addr    = wr_addr_reg;
  assign wr_len     = wr_len_reg;
  assign disp_bank  = disp_bank_reg;
  assign disp_valid = disp_valid_reg;
  assign frame_done = frame_done_reg;
  assign ovf        = ovf_reg;

endmodule

// File: tb/tb_ov5640_frame_wr_ctrl.sv
// Bench for ov5640_frame_wr_ctrl: random pixel streams, a behavioural memory
// writer, and expected bursts/data derived from frame length and bank rules.
module tb_ov5640_frame_wr_ctrl;

  localparam int          FP = 200;
  localparam int          BL = 64;
  localparam int          FD = 128;
  localparam int          AW = 24;
  localparam logic [23:0] B0 = 24'h000000;
  localparam logic [23:0] B1 = 24'h080000;

  logic        cam_pclk = 1'b0;
  logic        rst = 1'b1, enable = 1'b1, vsync = 1'b0, valid = 1'b0;
  logic [15:0] data = '0;
  logic        wr_req, wr_ack, wr_data_rd, wr_done;
  logic [23:0] wr_addr;
  logic [7:0]  wr_len;
  logic [15:0] wr_data;
  logic        disp_bank, disp_valid, frame_done, ovf, busy;

  int n_checks = 0, n_fail = 0;
  int ack_dly = 3, done_dly = 3;
  int wph = 0;
  int fd_cnt = 0;

  logic [23:0] got_addr[$], exp_addr[$];
  int          got_len[$],  exp_len[$];
  logic [15:0] got_data[$], exp_data[$], sent[$];
  logic        fd_bank[$];

  ov5640_frame_wr_ctrl #(
    .BURST_LEN(BL), .FIFO_DEPTH(FD), .ADDR_W(AW), .FRAME_PIXELS(FP),
    .BANK0_BASE(B0), .BANK1_BASE(B1)
  ) dut (
    .cam_pclk(cam_pclk), .rst(rst), .enable(enable),
    .cmos_frame_vsync(vsync), .cmos_frame_valid(valid), .cmos_frame_data(data),
    .wr_req(wr_req), .wr_ack(wr_ack), .wr_addr(wr_addr), .wr_len(wr_len),
    .wr_data(wr_data), .wr_data_rd(wr_data_rd), .wr_done(wr_done),
    .disp_bank(disp_bank), .disp_valid(disp_valid), .frame_done(frame_done),
    .ovf(ovf), .busy(busy)
  );

  always #5 cam_pclk = ~cam_pclk;

  // Memory writer model: ack after ack_dly, pop wr_len words, done after done_dly.
  initial begin : writer
    int cnt, left;
    cnt = 0; left = 0;
    wr_ack = 1'b0; wr_data_rd = 1'b0; wr_done = 1'b0;
    forever begin
      @(negedge cam_pclk);
      if (rst) begin
        wph = 0; wr_ack = 1'b0; wr_data_rd = 1'b0; wr_done = 1'b0;
      end else begin
        case (wph)
          0: begin
            wr_done = 1'b0;
            if (wr_req) begin
              got_addr.push_back(wr_addr);
              got_len.push_back(int'(wr_len));
              left = int'(wr_len);
              cnt  = ack_dly;
              wph  = 1;
            end
          end
          1: if (cnt <= 1) begin wr_ack = 1'b1; wph = 2; end else cnt--;
          2: begin
            wr_ack = 1'b0;
            wr_data_rd = 1'b1;
            got_data.push_back(wr_data);
            left--;
            if (left == 0) wph = 3;
          end
          3: begin wr_data_rd = 1'b0; cnt = done_dly; wph = 4; end
          default: if (cnt <= 1) begin wr_done = 1'b1; wph = 0; end else cnt--;
        endcase
      end
    end
  end

  initial begin : fd_monitor
    forever begin
      @(negedge cam_pclk);
      if (frame_done) begin
        fd_cnt++;
        fd_bank.push_back(disp_bank);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge cam_pclk);
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0; vsync = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic clear_sb();
    got_addr.delete(); got_len.delete(); got_data.delete();
    exp_addr.delete(); exp_len.delete(); exp_data.delete(); sent.delete();
  endtask

  task automatic vs_pulse();
    vsync = 1'b1; tick(1);
    vsync = 1'b0; tick(2);
  endtask

  task automatic send_pixels(int n, int gap_max);
    for (int i = 0; i < n; i++) begin
      valid = 1'b1;
      data  = 16'($urandom);
      sent.push_back(data);
      tick(1);
      valid = 1'b0;
      if (gap_max > 0) tick($urandom_range(0, gap_max));
    end
    valid = 1'b0;
  endtask

  task automatic wait_fd(int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (fd_cnt >= target) begin ok = 1'b1; break; end
      tick(1);
    end
  endtask

  // A frame of n stored words is cut into full bursts followed by one tail burst.
  function automatic void model_frame(logic [23:0] base, int nwords);
    int pos = 0;
    while (pos < nwords) begin
      int l;
      l = (nwords - pos >= BL) ? BL : nwords - pos;
      exp_addr.push_back(base + 24'(pos));
      exp_len.push_back(l);
      pos += l;
    end
  endfunction

  function automatic void model_data(int first, int count);
    for (int i = 0; i < count; i++) exp_data.push_back(sent[first + i]);
  endfunction

  task automatic test_reset();
    rst = 1'b1; tick(2);
    n_checks++; if (wr_req !== 1'b0) begin n_fail++; $display("FAIL reset_wr_req: got %b expected 0", wr_req); end
    n_checks++; if (wr_addr !== B0) begin n_fail++; $display("FAIL reset_wr_addr: got %h expected %h", wr_addr, B0); end
    n_checks++; if (wr_len !== 8'd0) begin n_fail++; $display("FAIL reset_wr_len: got %0d expected 0", wr_len); end
    n_checks++; if (disp_bank !== 1'b0) begin n_fail++; $display("FAIL reset_disp_bank: got %b expected 0", disp_bank); end
    n_checks++; if (disp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_disp_valid: got %b expected 0", disp_valid); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0; tick(2);
    enable = 1'b0;
    vs_pulse();
    tick(2);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL disabled_start: busy got %b expected 0", busy); end
    enable = 1'b1;
    $display("test_reset: done, %0d failures so far", n_fail);
  endtask

  task automatic test_single_frame();
    bit ok, mism;
    int fd0;
    do_reset(); clear_sb(); ack_dly = 3; fd0 = fd_cnt;
    vs_pulse();
    send_pixels(FP, 2);
    wait_fd(fd0 + 1, ok);
    tick(10);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_timeout: frame_done count %0d expected %0d", fd_cnt - fd0, 1); end
    model_frame(B0, FP); model_data(0, FP);
    n_checks++; if (got_addr.size() != exp_addr.size()) begin n_fail++; $display("FAIL single_nbursts: got %0d expected %0d", got_addr.size(), exp_addr.size()); end
    foreach (exp_addr[i]) if (i < got_addr.size()) begin
      n_checks++;
      if (got_addr[i] !== exp_addr[i] || got_len[i] != exp_len[i]) begin n_fail++; $display("FAIL single_burst%0d: got (%h,%0d) expected (%h,%0d)", i, got_addr[i], got_len[i], exp_addr[i], exp_len[i]); end
    end
    mism = (got_data.size() != exp_data.size());
    foreach (exp_data[i]) if (i < got_data.size() && got_data[i] !== exp_data[i]) mism = 1'b1;
    n_checks++; if (mism) begin n_fail++; $display("FAIL single_data: got %0d words (mismatching), expected %0d matching words", got_data.size(), exp_data.size()); end
    n_checks++; if (fd_cnt - fd0 != 1) begin n_fail++; $display("FAIL single_fd_count: got %0d expected 1", fd_cnt - fd0); end
    n_checks++; if (disp_bank !== 1'b0 || disp_valid !== 1'b1) begin n_fail++; $display("FAIL single_disp: got bank %b valid %b expected bank 0 valid 1", disp_bank, disp_valid); end
    n_checks++; if (ovf !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_status: got ovf %b busy %b expected 0 0", ovf, busy); end
    $display("test_single_frame: %0d bursts, %0d words, %0d failures so far", got_addr.size(), got_data.size(), n_fail);
  endtask

  task automatic test_back_to_back();
    bit ok, mism;
    int fd0, fb0;
    logic exp_bank [3];
    exp_bank[0] = 1'b0; exp_bank[1] = 1'b1; exp_bank[2] = 1'b0;
    do_reset(); clear_sb(); ack_dly = $urandom_range(1, 6); fd0 = fd_cnt; fb0 = fd_bank.size();
    for (int f = 0; f < 3; f++) begin
      vs_pulse();
      send_pixels(FP, 1);
      wait_fd(fd0 + f + 1, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_timeout%0d: frame_done count %0d expected %0d", f, fd_cnt - fd0, f + 1); end
      model_frame(exp_bank[f] ? B1 : B0, FP);
      model_data(f * FP, FP);
      tick(3);
    end
    n_checks++; if (got_addr.size() != exp_addr.size()) begin n_fail++; $display("FAIL b2b_nbursts: got %0d expected %0d", got_addr.size(), exp_addr.size()); end
    foreach (exp_addr[i]) if (i < got_addr.size()) begin
      n_checks++;
      if (got_addr[i] !== exp_addr[i] || got_len[i] != exp_len[i]) begin n_fail++; $display("FAIL b2b_burst%0d: got (%h,%0d) expected (%h,%0d)", i, got_addr[i], got_len[i], exp_addr[i], exp_len[i]); end
    end
    mism = (got_data.size() != exp_data.size());
    foreach (exp_data[i]) if (i < got_data.size() && got_data[i] !== exp_data[i]) mism = 1'b1;
    n_checks++; if (mism) begin n_fail++; $display("FAIL b2b_data: got %0d words (mismatching), expected %0d matching words", got_data.size(), exp_data.size()); end
    for (int f = 0; f < 3; f++) begin
      n_checks++;
      if (fb0 + f >= fd_bank.size()) begin n_fail++; $display("FAIL b2b_disp_bank%0d: no publish, expected bank %b", f, exp_bank[f]); end
      else if (fd_bank[fb0 + f] !== exp_bank[f]) begin n_fail++; $display("FAIL b2b_disp_bank%0d: got %b expected %b", f, fd_bank[fb0 + f], exp_bank[f]); end
    end
    $display("test_back_to_back: %0d bursts, %0d publishes, %0d failures so far", got_addr.size(), fd_bank.size() - fb0, n_fail);
  endtask

  task automatic test_stall_overflow();
    bit ok, mism;
    int fd0;
    do_reset(); clear_sb(); ack_dly = 3;
    vs_pulse(); send_pixels(FP, 0);
    wait_fd(fd_cnt + 1, ok);
    tick(5);
    clear_sb(); fd0 = fd_cnt; ack_dly = 200;
    vs_pulse();
    send_pixels(FP, 0);
    ack_dly = 3;
    tick(500);
    model_frame(B1, FD); model_data(0, FD);
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL stall_ovf: got %b expected 1", ovf); end
    n_checks++; if (fd_cnt != fd0) begin n_fail++; $display("FAIL stall_no_publish: frame_done count %0d expected 0", fd_cnt - fd0); end
    n_checks++; if (disp_bank !== 1'b0 || disp_valid !== 1'b1) begin n_fail++; $display("FAIL stall_disp: got bank %b valid %b expected bank 0 valid 1", disp_bank, disp_valid); end
    n_checks++; if (got_addr.size() != exp_addr.size()) begin n_fail++; $display("FAIL stall_nbursts: got %0d expected %0d", got_addr.size(), exp_addr.size()); end
    foreach (exp_addr[i]) if (i < got_addr.size()) begin
      n_checks++;
      if (got_addr[i] !== exp_addr[i] || got_len[i] != exp_len[i]) begin n_fail++; $display("FAIL stall_burst%0d: got (%h,%0d) expected (%h,%0d)", i, got_addr[i], got_len[i], exp_addr[i], exp_len[i]); end
    end
    mism = (got_data.size() != exp_data.size());
    foreach (exp_data[i]) if (i < got_data.size() && got_data[i] !== exp_data[i]) mism = 1'b1;
    n_checks++; if (mism) begin n_fail++; $display("FAIL stall_data: got %0d words, expected the first %0d pixels only", got_data.size(), exp_data.size()); end
    clear_sb();
    vs_pulse();
    send_pixels(FP, 1);
    wait_fd(fd0 + 1, ok);
    tick(3);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_next_timeout: frame_done count %0d expected 1", fd_cnt - fd0); end
    n_checks++; if (got_addr.size() == 0 || got_addr[0] !== B1) begin n_fail++; $display("FAIL stall_same_bank: got first addr %h (%0d bursts) expected %h", got_addr.size() ? got_addr[0] : 24'hx, got_addr.size(), B1); end
    n_checks++; if (disp_bank !== 1'b1) begin n_fail++; $display("FAIL stall_next_disp_bank: got %b expected 1", disp_bank); end
    $display("test_stall_overflow: %0d failures so far", n_fail);
  endtask

  task automatic test_abort();
    bit ok, mism;
    int fd0;
    do_reset(); clear_sb(); fd0 = fd_cnt; ack_dly = 50;
    vs_pulse();
    send_pixels(100, 0);
    vsync = 1'b1; tick(1); vsync = 1'b0;
    ack_dly = 3;
    tick(150);
    send_pixels(FP, 1);
    wait_fd(fd0 + 1, ok);
    tick(5);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL abort_timeout: frame_done count %0d expected 1", fd_cnt - fd0); end
    exp_addr.push_back(B0); exp_len.push_back(BL); model_data(0, BL);
    model_frame(B0, FP); model_data(100, FP);
    n_checks++; if (got_addr.size() != exp_addr.size()) begin n_fail++; $display("FAIL abort_nbursts: got %0d expected %0d", got_addr.size(), exp_addr.size()); end
    foreach (exp_addr[i]) if (i < got_addr.size()) begin
      n_checks++;
      if (got_addr[i] !== exp_addr[i] || got_len[i] != exp_len[i]) begin n_fail++; $display("FAIL abort_burst%0d: got (%h,%0d) expected (%h,%0d)", i, got_addr[i], got_len[i], exp_addr[i], exp_len[i]); end
    end
    mism = (got_data.size() != exp_data.size());
    foreach (exp_data[i]) if (i < got_data.size() && got_data[i] !== exp_data[i]) mism = 1'b1;
    n_checks++; if (mism) begin n_fail++; $display("FAIL abort_data: got %0d words (mismatching), expected %0d matching words", got_data.size(), exp_data.size()); end
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL abort_ovf: got %b expected 1", ovf); end
    n_checks++; if (fd_cnt - fd0 != 1 || disp_bank !== 1'b0) begin n_fail++; $display("FAIL abort_publish: got %0d publishes bank %b expected 1 publish bank 0", fd_cnt - fd0, disp_bank); end
    $display("test_abort: %0d bursts, %0d failures so far", got_addr.size(), n_fail);
  endtask

  task automatic test_excess_pixels();
    bit ok, mism;
    int fd0;
    do_reset(); clear_sb(); fd0 = fd_cnt; ack_dly = $urandom_range(1, 5);
    vs_pulse();
    send_pixels(250, 1);
    wait_fd(fd0 + 1, ok);
    tick(10);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL excess_timeout: frame_done count %0d expected 1", fd_cnt - fd0); end
    model_frame(B0, FP); model_data(0, FP);
    n_checks++; if (got_addr.size() != exp_addr.size()) begin n_fail++; $display("FAIL excess_nbursts: got %0d expected %0d", got_addr.size(), exp_addr.size()); end
    foreach (exp_addr[i]) if (i < got_addr.size()) begin
      n_checks++;
      if (got_addr[i] !== exp_addr[i] || got_len[i] != exp_len[i]) begin n_fail++; $display("FAIL excess_burst%0d: got (%h,%0d) expected (%h,%0d)", i, got_addr[i], got_len[i], exp_addr[i], exp_len[i]); end
    end
    mism = (got_data.size() != exp_data.size());
    foreach (exp_data[i]) if (i < got_data.size() && got_data[i] !== exp_data[i]) mism = 1'b1;
    n_checks++; if (mism) begin n_fail++; $display("FAIL excess_data: got %0d words (mismatching), expected %0d matching words", got_data.size(), exp_data.size()); end
    n_checks++; if (fd_cnt - fd0 != 1 || ovf !== 1'b0) begin n_fail++; $display("FAIL excess_status: got %0d publishes ovf %b expected 1 publish ovf 0", fd_cnt - fd0, ovf); end
    $display("test_excess_pixels: %0d words written, %0d failures so far", got_data.size(), n_fail);
  endtask

  task automatic test_reset_in_burst();
    bit ok, mism;
    int fd0;
    do_reset(); clear_sb(); ack_dly = 3;
    vs_pulse(); send_pixels(FP, 0);
    wait_fd(fd_cnt + 1, ok);
    tick(5);
    vs_pulse();
    for (int i = 0; i < 200 && wph != 2; i++) begin
      valid = 1'b1; data = 16'($urandom); tick(1);
    end
    n_checks++; if (wph != 2) begin n_fail++; $display("FAIL rstburst_reach: writer phase %0d expected 2 (popping)", wph); end
    rst = 1'b1; valid = 1'b0;
    tick(1);
    n_checks++; if (wr_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstburst_ctrl: got wr_req %b busy %b expected 0 0", wr_req, busy); end
    n_checks++; if (disp_valid !== 1'b0 || disp_bank !== 1'b0) begin n_fail++; $display("FAIL rstburst_disp: got valid %b bank %b expected 0 0", disp_valid, disp_bank); end
    n_checks++; if (wr_addr !== B0) begin n_fail++; $display("FAIL rstburst_addr: got %h expected %h", wr_addr, B0); end
    tick(1); rst = 1'b0; tick(2);
    clear_sb(); fd0 = fd_cnt;
    vs_pulse();
    send_pixels(FP, 1);
    wait_fd(fd0 + 1, ok);
    tick(5);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rstburst_timeout: frame_done count %0d expected 1", fd_cnt - fd0); end
    model_frame(B0, FP); model_data(0, FP);
    n_checks++; if (got_addr.size() != exp_addr.size()) begin n_fail++; $display("FAIL rstburst_nbursts: got %0d expected %0d", got_addr.size(), exp_addr.size()); end
    foreach (exp_addr[i]) if (i < got_addr.size()) begin
      n_checks++;
      if (got_addr[i] !== exp_addr[i] || got_len[i] != exp_len[i]) begin n_fail++; $display("FAIL rstburst_burst%0d: got (%h,%0d) expected (%h,%0d)", i, got_addr[i], got_len[i], exp_addr[i], exp_len[i]); end
    end
    mism = (got_data.size() != exp_data.size());
    foreach (exp_data[i]) if (i < got_data.size() && got_data[i] !== exp_data[i]) mism = 1'b1;
    n_checks++; if (mism) begin n_fail++; $display("FAIL rstburst_data: got %0d words (stale or mismatching), expected %0d matching words", got_data.size(), exp_data.size()); end
    n_checks++; if (disp_bank !== 1'b0 || disp_valid !== 1'b1) begin n_fail++; $display("FAIL rstburst_publish: got bank %b valid %b expected bank 0 valid 1", disp_bank, disp_valid); end
    $display("test_reset_in_burst: %0d failures so far", n_fail);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_stall_overflow();
    test_abort();
    test_excess_pixels();
    test_reset_in_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ov5640_frame_wr_ctrl.md
Name: ov5640_frame_wr_ctrl

Overview:
- Write-side scheduler between the OV5640 capture stage (16-bit RGB565 pixel stream with frame-vsync and valid) and the external frame-buffer memory writer.
- Buffers pixels in an internal FIFO and issues fixed-length burst write requests.
- Tracks per-frame pixel and address progress and ping-pongs between two frame banks.
- Publishes the last complete bank to the display side; bad or short frames never reach display.

Parameters:
- BURST_LEN, 64, words per full burst (1..255)
- FIFO_DEPTH, 256, pixel FIFO depth, power of two, must be >= 2*BURST_LEN
- ADDR_W, 24, memory word-address width
- FRAME_PIXELS, 307200, pixels per frame (640x480)
- BANK0_BASE, 24'h000000, word base address of bank 0
- BANK1_BASE, 24'h080000, word base address of bank 1

Ports:
- cam_pclk  in  1  pixel clock; the only clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  capture enable, sampled at frame start
- cmos_frame_vsync  in  1  frame sync from capture stage; rising edge = frame start
- cmos_frame_valid  in  1  pixel strobe
- cmos_frame_data  in  16  RGB565 pixel
- wr_req  out  1  burst request
- wr_ack  in  1  one-cycle request accept
- wr_addr  out  ADDR_W  burst start word address
- wr_len  out  8  burst length in words
- wr_data  out  16  FIFO head (show-ahead)
- wr_data_rd  in  1  writer pops one word
- wr_done  in  1  one-cycle burst-complete pulse
- disp_bank  out  1  last completed bank
- disp_valid  out  1  disp_bank holds a complete frame
- frame_done  out  1  one-cycle pulse on bank publish
- ovf  out  1  sticky error: FIFO overflow or short frame
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset: wr_req=0, wr_addr=BANK0_BASE, wr_len=0, disp_bank=0, disp_valid=0, frame_done=0, ovf=0, busy=0. FIFO is emptied, wr_bank=0, FSM=IDLE. Reset takes effect in any state and drops wr_req on the next edge.
- vsync edge: vsync is registered once internally; vs_rise = vsync_q=0 && vsync=1, a one-cycle pulse.
- FIFO input: push on cmos_frame_valid only while FSM is in CAPT/REQ/BURST and in_cnt < FRAME_PIXELS.
  - Pixels beyond FRAME_PIXELS are discarded silently.
  - Push while full: pixel dropped, ovf<=1, frame_bad<=1.
- FIFO output: wr_data_rd pops the head. A pop when empty is ignored. Simultaneous push+pop is allowed and leaves count unchanged.
- FSM states: IDLE, CAPT, REQ, BURST, DONE, ABORT.
- IDLE: on vs_rise && enable -> CAPT. Clear in_cnt, out_cnt and frame_bad; wr_addr <= base(wr_bank).
- CAPT, evaluated in priority order:
  - vs_rise -> ABORT (short frame, ovf<=1).
  - fifo_cnt >= BURST_LEN -> REQ with wr_len=BURST_LEN.
  - in_cnt==FRAME_PIXELS && fifo_cnt>0 && fifo_cnt<BURST_LEN -> REQ with wr_len=fifo_cnt (tail burst).
  - out_cnt==FRAME_PIXELS -> DONE.
- REQ: wr_req=1 and wr_addr/wr_len are held stable until wr_ack, then wr_req=0 on the next cycle -> BURST.
  - wr_ack is accepted only when wr_req=1.
  - A vs_rise seen in REQ/BURST latches abort_pend.
- BURST: on wr_done, wr_addr += wr_len and out_cnt += wr_len.
  - Go to ABORT if abort_pend is set, otherwise back to CAPT.
  - A burst is never cut short.
- DONE, one cycle:
  - If frame_bad=0: frame_done=1, disp_bank<=wr_bank, disp_valid<=1, wr_bank<=~wr_bank.
  - If frame_bad=1: no publish and no bank swap.
  - -> IDLE.
- ABORT: flush the FIFO (count to 0) in one cycle, no publish, no bank swap. If the abort was caused by vs_rise and enable=1 -> CAPT (new frame started, counters cleared). Otherwise -> IDLE.
- Address arithmetic: unsigned modulo 2^ADDR_W. out_cnt and in_cnt are 19 bits (ceil(log2(FRAME_PIXELS+1))).
- Dropping enable mid-frame has no effect until the next frame start.
- ovf is cleared only by rst.

Test Plan:
- FRAME_PIXELS=200, BURST_LEN=64, FIFO_DEPTH=128, enable=1, one frame of 200 pixels, wr_ack/wr_done returned after 3 cycles -> bursts (addr,len) = (0,64),(64,64),(128,64),(192,8). Then frame_done pulses once, disp_bank=0, disp_valid=1, next frame writes from BANK1_BASE.
- Two consecutive good frames -> bank sequence 0 then 1; disp_bank sequence 0,1; third frame restarts at BANK0_BASE.
- Writer stalls wr_ack for 200 cycles while 200 pixels arrive back-to-back -> ovf=1, at least 72 pixels dropped, no frame_done, disp_bank unchanged, next frame reuses the same bank.
- vs_rise after 100 pixels, with a burst in flight -> burst completes, FIFO flushes, ovf=1, no publish, new capture starts at base(wr_bank) with in_cnt=0.
- 250 valid pixels in a 200-pixel frame -> only 200 pixels written; last burst len=8; normal frame_done.
- Assert rst during BURST -> next cycle wr_req=0, busy=0, disp_valid=0, wr_addr=BANK0_BASE, and FIFO empty.
